// File: rtl/img_ddr_writer.sv
// rtl/img_ddr_writer.sv - drains the packet FIFO into a ring of DDR frame slots using fixed-length write bursts
module img_ddr_writer #(
    parameter int          FRAME_WORDS = 262400,
    parameter int          BURST_LEN   = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter logic [31:0] SLOT_STRIDE = 32'h0011_0000,
    parameter int          FRAME_SLOTS = 4,
    parameter int          CNT_W       = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [31:0]                    fifo_dout,
    input  logic                           fifo_empty,
    input  logic [CNT_W-1:0]               fifo_rd_count,
    output logic                           fifo_rden,
    input  logic                           wr_en,
    output logic                           cmd_valid,
    input  logic                           cmd_ready,
    output logic [31:0]                    cmd_addr,
    output logic [7:0]                     cmd_len,
    output logic [31:0]                    wdata,
    output logic                           wvalid,
    input  logic                           wready,
    output logic                           wlast,
    input  logic                           bvalid,
    input  logic [1:0]                     bresp,
    output logic                           bready,
    input  logic [1:0]                     frame_type_i,
    output logic                           frame_done,
    output logic [$clog2(FRAME_SLOTS)-1:0] frame_slot,
    output logic [1:0]                     frame_type_o,
    input  logic                           slot_release,
    output logic [4:0]                     pending_cnt,
    output logic                           slot_stall,
    output logic                           wr_err
);
    localparam int SLOT_W = $clog2(FRAME_SLOTS);
    localparam int WC_W   = $clog2(FRAME_WORDS + 1);
    localparam int BEAT_W = $clog2(BURST_LEN);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_FRAME_START = 3'd1;
    localparam logic [2:0] S_CMD         = 3'd2;
    localparam logic [2:0] S_DATA        = 3'd3;
    localparam logic [2:0] S_RESP        = 3'd4;
    localparam logic [2:0] S_FRAME_END   = 3'd5;

    logic [2:0]        state;
    logic [SLOT_W-1:0] wr_slot;
    logic [WC_W-1:0]   word_cnt;
    logic [BEAT_W-1:0] beat;
    logic [31:0]       slot_base;
    logic [1:0]        frame_type_q;
    logic              ring_full;
    logic              beat_last;
    logic              pend_inc;
    logic              pend_dec;

    assign ring_full = (pending_cnt == 5'(FRAME_SLOTS));
    assign beat_last = (beat == BEAT_W'(BURST_LEN - 1));
    assign pend_inc  = (state == S_FRAME_END);
    // A release with nothing outstanding is dropped so the counter never wraps
    assign pend_dec  = slot_release && (pending_cnt != 5'd0);

    assign wvalid       = (state == S_DATA);
    assign wdata        = wvalid ? fifo_dout : 32'd0;
    assign wlast        = wvalid && beat_last;
    assign fifo_rden    = wvalid && wready;
    assign bready       = (state == S_RESP);
    assign frame_done   = (state == S_FRAME_END);
    assign frame_slot   = frame_done ? wr_slot : '0;
    assign frame_type_o = frame_done ? frame_type_q : 2'd0;
    assign slot_stall   = (state == S_FRAME_START) && ring_full;
    assign cmd_len      = cmd_valid ? 8'(BURST_LEN - 1) : 8'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            wr_slot      <= '0;
            word_cnt     <= '0;
            beat         <= '0;
            slot_base    <= 32'd0;
            frame_type_q <= 2'd0;
            cmd_valid    <= 1'b0;
            cmd_addr     <= 32'd0;
            wr_err       <= 1'b0;
            pending_cnt  <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wr_en && !fifo_empty)
                        state <= S_FRAME_START;
                end
                S_FRAME_START: begin
                    if (!ring_full) begin
                        word_cnt     <= '0;
                        frame_type_q <= frame_type_i;
                        slot_base    <= BASE_ADDR + 32'(wr_slot) * SLOT_STRIDE;
                        state        <= S_CMD;
                    end
                end
                S_CMD: begin
                    // Burst is only requested once the whole burst is in the FIFO
                    if (cmd_valid) begin
                        if (cmd_ready) begin
                            cmd_valid <= 1'b0;
                            beat      <= '0;
                            state     <= S_DATA;
                        end
                    end else if (32'(fifo_rd_count) >= 32'(BURST_LEN)) begin
                        cmd_valid <= 1'b1;
                        cmd_addr  <= slot_base + (32'(word_cnt) << 2);
                    end
                end
                S_DATA: begin
                    if (wready) begin
                        beat     <= beat + BEAT_W'(1);
                        word_cnt <= word_cnt + WC_W'(1);
                        if (beat_last)
                            state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bvalid) begin
                        if (bresp != 2'b00)
                            wr_err <= 1'b1;
                        state <= (word_cnt == WC_W'(FRAME_WORDS)) ? S_FRAME_END : S_CMD;
                    end
                end
                S_FRAME_END: begin
                    wr_slot <= wr_slot + SLOT_W'(1);
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (pend_inc && !pend_dec)
                pending_cnt <= pending_cnt + 5'd1;
            else if (pend_dec && !pend_inc)
                pending_cnt <= pending_cnt - 5'd1;
        end
    end
endmodule

// File: tb/tb_img_ddr_writer.sv
// tb/tb_img_ddr_writer.sv - bench for img_ddr_writer
module tb_img_ddr_writer;
    localparam int          FW     = 64;
    localparam int          BL     = 16;
    localparam int          NS     = 4;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] STRIDE = 32'h0011_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic [15:0] fifo_rd_count;
    logic        fifo_rden;
    logic        wr_en;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic        wlast;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;
    logic [1:0]  frame_type_i;
    logic        frame_done;
    logic [1:0]  frame_slot;
    logic [1:0]  frame_type_o;
    logic        slot_release;
    logic [4:0]  pending_cnt;
    logic        slot_stall;
    logic        wr_err;

    img_ddr_writer #(
        .FRAME_WORDS(FW), .BURST_LEN(BL), .BASE_ADDR(BASE),
        .SLOT_STRIDE(STRIDE), .FRAME_SLOTS(NS), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_count(fifo_rd_count), .fifo_rden(fifo_rden), .wr_en(wr_en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
        .bvalid(bvalid), .bresp(bresp), .bready(bready), .frame_type_i(frame_type_i),
        .frame_done(frame_done), .frame_slot(frame_slot), .frame_type_o(frame_type_o),
        .slot_release(slot_release), .pending_cnt(pending_cnt), .slot_stall(slot_stall),
        .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    logic [31:0] exp_q[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_last[$];
    int          beat_idx, rden_cnt, resp_cnt, done_cnt, cmdv_seen;
    logic [31:0] done_slot, done_type, obs_len, hold_addr;
    bit          hold_pend, rnd_bp, rel_on_done;
    int          err_burst;
    int          exp_slot, exp_pending;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_dout     = (q.size() != 0) ? q[0] : 32'd0;
        fifo_empty    = (q.size() == 0);
        fifo_rd_count = 16'(q.size());
    endtask

    // Observe the settled cycle at negedge, then apply its effects just after the posedge
    task automatic tick();
        bit pop;
        @(negedge clk);
        if (hold_pend) begin
            chk("cmd_hold_valid", 32'(cmd_valid), 32'd1);
            chk("cmd_hold_addr", cmd_addr, hold_addr);
        end
        hold_pend = cmd_valid && !cmd_ready;
        hold_addr = cmd_addr;
        if (cmd_valid) cmdv_seen++;
        if (cmd_valid && cmd_ready) begin
            obs_addr.push_back(cmd_addr);
            obs_len = 32'(cmd_len);
        end
        if (wvalid && wready) begin
            obs_data.push_back(wdata);
            if (wlast) obs_last.push_back(beat_idx);
            beat_idx++;
        end
        pop = fifo_rden;
        if (fifo_rden) rden_cnt++;
        if (bvalid && bready) resp_cnt++;
        if (frame_done) begin
            done_cnt++;
            done_slot = 32'(frame_slot);
            done_type = 32'(frame_type_o);
        end
        @(posedge clk);
        #1;
        if (pop && q.size() != 0) void'(q.pop_front());
        drive_fifo();
        cmd_ready    = rnd_bp ? 1'($urandom) : 1'b1;
        wready       = rnd_bp ? 1'($urandom) : 1'b1;
        bvalid       = rnd_bp ? 1'($urandom) : 1'b1;
        bresp        = (resp_cnt == err_burst) ? 2'b10 : 2'b00;
        slot_release = rel_on_done && frame_done;
    endtask

    task automatic push_frame(input bit seq);
        logic [31:0] w;
        exp_q.delete();
        for (int i = 0; i < FW; i++) begin
            w = seq ? 32'(i) : $urandom;
            q.push_back(w);
            exp_q.push_back(w);
        end
        drive_fifo();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        chk({tag, "_cmd_addr"}, cmd_addr, 32'd0);
        chk({tag, "_cmd_len"}, 32'(cmd_len), 32'd0);
        chk({tag, "_wvalid"}, 32'(wvalid), 32'd0);
        chk({tag, "_wdata"}, wdata, 32'd0);
        chk({tag, "_wlast"}, 32'(wlast), 32'd0);
        chk({tag, "_fifo_rden"}, 32'(fifo_rden), 32'd0);
        chk({tag, "_bready"}, 32'(bready), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_frame_slot"}, 32'(frame_slot), 32'd0);
        chk({tag, "_frame_type_o"}, 32'(frame_type_o), 32'd0);
        chk({tag, "_pending_cnt"}, 32'(pending_cnt), 32'd0);
        chk({tag, "_slot_stall"}, 32'(slot_stall), 32'd0);
        chk({tag, "_wr_err"}, 32'(wr_err), 32'd0);
    endtask

    // Reference: frame in slot s is written as FW/BL bursts at BASE + s*STRIDE + k*BL*4
    task automatic run_frame(input logic [1:0] ftype, input bit rnd, input int errb, input bit rel);
        int bad;
        int c;
        frame_type_i = ftype;
        rnd_bp       = rnd;
        err_burst    = errb;
        rel_on_done  = rel;
        obs_addr.delete();
        obs_data.delete();
        obs_last.delete();
        beat_idx = 0; rden_cnt = 0; resp_cnt = 0; done_cnt = 0; obs_len = 32'hFFFF_FFFF;
        c = 0;
        while (c < 4000 && done_cnt == 0) begin
            tick();
            c++;
        end
        chk("frame_done_seen", 32'(done_cnt), 32'd1);
        chk("burst_count", 32'(obs_addr.size()), 32'(FW / BL));
        for (int k = 0; k < obs_addr.size(); k++)
            chk("cmd_addr", obs_addr[k], BASE + 32'(exp_slot) * STRIDE + 32'(k * BL * 4));
        chk("beat_count", 32'(obs_data.size()), 32'(FW));
        bad = 0;
        for (int i = 0; i < obs_data.size() && i < exp_q.size(); i++)
            if (obs_data[i] !== exp_q[i]) bad++;
        chk("wdata_mismatches", 32'(bad), 32'd0);
        chk("wlast_count", 32'(obs_last.size()), 32'(FW / BL));
        for (int k = 0; k < obs_last.size(); k++)
            chk("wlast_pos", 32'(obs_last[k]), 32'(BL * (k + 1) - 1));
        chk("rden_count", 32'(rden_cnt), 32'(FW));
        chk("cmd_len", obs_len, 32'(BL - 1));
        chk("frame_slot", done_slot, 32'(exp_slot));
        chk("frame_type", done_type, 32'(ftype));
        exp_slot = (exp_slot + 1) % NS;
        if (!rel) exp_pending++;
        chk("pending_cnt", 32'(pending_cnt), 32'(exp_pending));
        rnd_bp = 0; err_burst = -1; rel_on_done = 0;
        cmd_ready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    endtask

    initial begin
        int c;
        rst = 1'b1; wr_en = 1'b0; cmd_ready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        bresp = 2'b00; frame_type_i = 2'd0; slot_release = 1'b0;
        hold_pend = 0; rnd_bp = 0; rel_on_done = 0; err_burst = -1;
        drive_fifo();
        repeat (3) tick();
        check_zero("reset");
        rst = 1'b0;
        wr_en = 1'b1;
        exp_slot = 0;
        exp_pending = 0;

        push_frame(1); run_frame(2'd0, 0, -1, 0);
        push_frame(0); run_frame(2'($urandom), 1, -1, 0);
        push_frame(0); run_frame(2'($urandom), 1, -1, 0);
        push_frame(0); run_frame(2'($urandom), 0, -1, 0);

        // Ring full: fifth frame must wait for a release
        push_frame(0);
        cmdv_seen = 0;
        repeat (20) tick();
        chk("slot_stall_full", 32'(slot_stall), 32'd1);
        chk("no_cmd_while_full", 32'(cmdv_seen), 32'd0);
        slot_release = 1'b1;
        exp_pending--;
        tick();
        chk("stall_after_release", 32'(slot_stall), 32'd0);
        chk("pending_after_release", 32'(pending_cnt), 32'(exp_pending));
        run_frame(2'd3, 0, -1, 0);

        for (int i = 0; i < NS; i++) begin
            slot_release = 1'b1;
            tick();
            exp_pending--;
        end
        chk("pending_drained", 32'(pending_cnt), 32'(exp_pending));
        slot_release = 1'b1;
        tick();
        chk("release_at_zero", 32'(pending_cnt), 32'd0);

        push_frame(0); run_frame(2'd1, 0, 1, 0);
        chk("wr_err_set", 32'(wr_err), 32'd1);
        push_frame(0); run_frame(2'($urandom), 1, -1, 0);
        chk("wr_err_sticky", 32'(wr_err), 32'd1);

        // Reset while offering beat 7 of the first burst
        push_frame(0);
        beat_idx = 0;
        c = 0;
        while (c < 500 && !(wvalid && beat_idx == 7)) begin
            tick();
            c++;
        end
        chk("reached_beat7", 32'(beat_idx), 32'd7);
        rst = 1'b1;
        q.delete();
        drive_fifo();
        tick();
        check_zero("mid_rst");
        rst = 1'b0;
        hold_pend = 0;
        exp_slot = 0;
        exp_pending = 0;
        push_frame(0); run_frame(2'd2, 0, -1, 0);
        chk("wr_err_cleared", 32'(wr_err), 32'd0);
        push_frame(0); run_frame(2'($urandom), 1, -1, 0);
        push_frame(0); run_frame(2'($urandom), 0, -1, 1);
        chk("pending_coincident", 32'(pending_cnt), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/img_ddr_writer.md
Name: img_ddr_writer

Overview:
- Downstream neighbour of the image packet stage. Drains the packet FIFO, which holds the frame payload plus the parity, frame-info and flush words, and writes it to DDR.
- Writes use fixed-length bursts over a simple cmd/data/response write interface.
- DDR is managed as a ring of frame slots. Each slot is held until the downstream DDR->EMMC mover releases it.
- Emits a per-frame completion pulse carrying the slot index and frame type.

Parameters:
- FRAME_WORDS, 262400: 32-bit words per packed frame (payload + 1 line tail). Must be a multiple of BURST_LEN.
- BURST_LEN, 16: words per DDR write burst (2..256).
- BASE_ADDR, 32'h8000_0000: byte address of slot 0.
- SLOT_STRIDE, 32'h0011_0000: byte distance between slots. Must be >= FRAME_WORDS*4.
- FRAME_SLOTS, 4: number of slots in the ring. Power of 2, 2..16.
- CNT_W, 16: width of fifo_rd_count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- fifo_dout  in  32  first-word-fall-through FIFO read data.
- fifo_empty  in  1  FIFO empty.
- fifo_rd_count  in  CNT_W  words available in the FIFO.
- fifo_rden  out  1  FIFO pop.
- wr_en  in  1  block enable; sampled only at frame boundaries.
- cmd_valid  out  1  burst command valid.
- cmd_ready  in  1  burst command accept.
- cmd_addr  out  32  burst byte address.
- cmd_len  out  8  burst length minus 1 (= BURST_LEN-1).
- wdata  out  32  write data.
- wvalid  out  1  write data valid.
- wready  in  1  write data accept.
- wlast  out  1  last beat of burst.
- bvalid  in  1  write response valid.
- bresp  in  2  write response; nonzero means error.
- bready  out  1  write response accept.
- frame_type_i  in  2  frame type from the packet stage; stable during the frame.
- frame_done  out  1  one-cycle pulse when a frame is fully committed to DDR.
- frame_slot  out  log2(FRAME_SLOTS)  slot of the completed frame; valid with frame_done.
- frame_type_o  out  2  type of the completed frame; valid with frame_done.
- slot_release  in  1  pulse: oldest pending slot freed.
- pending_cnt  out  5  committed, unreleased frames.
- slot_stall  out  1  ring full; waiting for a release.
- wr_err  out  1  sticky: a nonzero bresp was seen.

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. This includes pending_cnt, write slot, word counter, burst beat counter and wr_err. Reset mid-burst abandons the burst and raises no error; the FIFO is reset by the system alongside this block.
- FSM states: IDLE, FRAME_START, CMD, DATA, RESP, FRAME_END.
- IDLE -> FRAME_START when wr_en=1 and fifo_empty=0.
- FRAME_START:
  - If pending_cnt == FRAME_SLOTS: assert slot_stall and stay.
  - Otherwise: clear the word counter, latch frame_type_i, set slot_base = BASE_ADDR + wr_slot*SLOT_STRIDE, go to CMD.
- CMD:
  - Wait until fifo_rd_count >= BURST_LEN, then drive cmd_valid=1 with cmd_addr = slot_base + word_cnt*4.
  - Hold cmd_valid and cmd_addr stable until cmd_ready.
  - On handshake, go to DATA with beat counter = 0.
- DATA:
  - wvalid = 1, wdata = fifo_dout, fifo_rden = wvalid & wready (same cycle, combinational from registered state).
  - wlast = (beat == BURST_LEN-1).
  - Beat counter and word_cnt advance only on wvalid & wready.
  - When the accepted beat has wlast=1, go to RESP.
  - The FIFO cannot underflow because the burst is only issued once BURST_LEN words are available.
- RESP:
  - bready = 1.
  - On bvalid: if bresp != 0, set wr_err (sticky until rst). Data is not retried.
  - If word_cnt == FRAME_WORDS, go to FRAME_END; else go to CMD.
- FRAME_END:
  - Pulse frame_done for 1 cycle with frame_slot = wr_slot and frame_type_o = latched type.
  - wr_slot <= wr_slot+1, wrapping modulo FRAME_SLOTS.
  - pending_cnt +1.
  - Go to IDLE.
- wr_en deasserted mid-frame: the current frame completes; the block stops at the next IDLE.
- pending_cnt update rules:
  - +1 on frame_done.
  - -1 on slot_release.
  - frame_done and slot_release in the same cycle: unchanged.
  - slot_release while pending_cnt == 0: ignored.
- slot_stall is 1 only while in FRAME_START with the ring full. It deasserts the cycle after a release is counted.
- Address arithmetic is 32-bit unsigned; overflow past 2^32 is a configuration error and is not checked.
- Latency:
  - cmd_valid rises 1 cycle after entering CMD once the count condition holds.
  - The first data beat is offered the cycle after the cmd handshake.

Test Plan:
- FRAME_WORDS=64, BURST_LEN=16, FIFO prefilled with 0..63, cmd_ready/wready/bvalid always 1 -> 4 bursts at cmd_addr 0x80000000, +0x40, +0x80, +0xC0; wdata sequence 0..63; wlast on beats 15/31/47/63; one frame_done with frame_slot=0 and pending_cnt=1.
- Random wready/cmd_ready backpressure (50%) on the same frame -> identical data and address sequence; cmd_addr/cmd_valid stable while waiting; fifo_rden pulses exactly 64 times.
- Four frames with no slot_release (FRAME_SLOTS=4), then a fifth frame queued -> slots 0,1,2,3 used, slot_stall=1 with no cmd_valid; one slot_release -> fifth frame written at slot 0 base (0x80000000).
- bresp=2'b10 on the second burst -> wr_err=1 and remains 1; frame still completes with frame_done; wr_err cleared only by rst.
- rst asserted mid-DATA on beat 7 -> next cycle all outputs 0, pending_cnt=0; the next frame starts at slot 0 base.
- frame_done and slot_release coincident with pending_cnt=2 -> pending_cnt stays 2; slot_release at pending_cnt=0 -> stays 0.
